// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the data memory responder and its helpers.
package riscv_pkg;

    // Load/store width encodings (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Responder FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // A captured load/store request
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  funct3;
        logic [31:0] wdata;
    } memReq_t;

    // Number of bytes touched by an access; illegal sizes report a word
    function automatic logic [2:0] accessSize(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   accessSize = 3'd1;
            2'b01:   accessSize = 3'd2;
            default: accessSize = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the core and the data memory.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/load_extend.sv
// Picks the byte/half lane out of an aligned word and sign/zero extends it.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Lane selection followed by the extension chosen by funct3
    always_comb begin
        byteSel = 8'h00;
        halfSel = 16'h0000;
        data_o  = 32'h0000_0000;
        case (lane_i)
            2'd0:    byteSel = word_i[7:0];
            2'd1:    byteSel = word_i[15:8];
            2'd2:    byteSel = word_i[23:16];
            default: byteSel = word_i[31:24];
        endcase
        halfSel = lane_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byteSel[7]}}, byteSel};
            F3_BU:   data_o = {24'h000000, byteSel};
            F3_H:    data_o = {{16{halfSel[15]}}, halfSel};
            F3_HU:   data_o = {16'h0000, halfSel};
            F3_W:    data_o = word_i;
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data memory answering one load/store at a time
// over valid/ready, with a fixed number of wait states before the access.
module data_mem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 0
) (
    input  logic clk,
    input  logic reset_n,
    data_mem_responder_if.slave bus
);

    localparam int         AW  = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    logic [7:0]  mem [0:DEPTH-1];

    logic [1:0]  state_q, state_d;
    logic [3:0]  count_q, count_d;
    memReq_t     reqLatch_q, reqLatch_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    memReq_t     reqIn;
    memReq_t     acc;
    logic        accept;
    logic        enterResp;
    logic        accErr;
    logic        memWrite;
    logic [32:0] lastByte;
    logic [31:0] rdWord;
    logic [31:0] extData;
    logic [AW-1:0] byteIdx;

    assign reqIn = '{write: bus.req_write, addr: bus.req_addr,
                     funct3: bus.req_funct3, wdata: bus.req_wdata};

    assign accept    = bus.req_valid && (state_q == ST_IDLE);
    assign enterResp = (accept && (LAT == 4'd0)) ||
                       ((state_q == ST_WAIT) && (count_q == 4'd1));

    // With zero wait states the access uses the live request, otherwise the latched one
    assign acc     = (state_q == ST_IDLE) ? reqIn : reqLatch_q;
    assign byteIdx = acc.addr[AW-1:0];

    // Reject out-of-range, misaligned and undefined-width accesses
    always_comb begin
        accErr   = 1'b0;
        lastByte = {1'b0, acc.addr} + {30'd0, accessSize(acc.funct3)} - 33'd1;
        if (lastByte >= 33'(DEPTH)) accErr = 1'b1;
        case (acc.funct3[1:0])
            2'b01:   if (acc.addr[0]) accErr = 1'b1;
            2'b10:   if (acc.addr[1:0] != 2'b00) accErr = 1'b1;
            2'b11:   accErr = 1'b1;
            default: ;
        endcase
        if (acc.write && acc.funct3[2]) accErr = 1'b1;
        if (!acc.write && (acc.funct3 == 3'b110)) accErr = 1'b1;
    end

    assign rdWord = {mem[{byteIdx[AW-1:2], 2'b11}], mem[{byteIdx[AW-1:2], 2'b10}],
                     mem[{byteIdx[AW-1:2], 2'b01}], mem[{byteIdx[AW-1:2], 2'b00}]};

    load_extend u_extend (
        .word_i   (rdWord),
        .lane_i   (acc.addr[1:0]),
        .funct3_i (acc.funct3),
        .data_o   (extData)
    );

    assign memWrite = enterResp && acc.write && !accErr;

    // Store commit on the edge entering RESP; the array itself is never reset
    always_ff @(posedge clk) begin
        if (reset_n && memWrite) begin
            case (acc.funct3[1:0])
                2'b00: mem[byteIdx] <= acc.wdata[7:0];
                2'b01: begin
                    mem[{byteIdx[AW-1:1], 1'b0}] <= acc.wdata[7:0];
                    mem[{byteIdx[AW-1:1], 1'b1}] <= acc.wdata[15:8];
                end
                default: begin
                    mem[{byteIdx[AW-1:2], 2'b00}] <= acc.wdata[7:0];
                    mem[{byteIdx[AW-1:2], 2'b01}] <= acc.wdata[15:8];
                    mem[{byteIdx[AW-1:2], 2'b10}] <= acc.wdata[23:16];
                    mem[{byteIdx[AW-1:2], 2'b11}] <= acc.wdata[31:24];
                end
            endcase
        end
    end

    // Handshake FSM, wait counter and response capture
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        reqLatch_d = reqLatch_q;
        rdata_d    = rdata_q;
        error_d    = error_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    reqLatch_d = reqIn;
                    if (LAT == 4'd0) begin
                        state_d = ST_RESP;
                    end else begin
                        count_d = LAT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (enterResp) begin
            error_d = accErr;
            rdata_d = (accErr || acc.write) ? 32'h0000_0000 : extData;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            count_q    <= 4'd0;
            reqLatch_q <= '0;
            rdata_q    <= 32'h0000_0000;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reqLatch_q <= reqLatch_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_error = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: a zero-wait-state memory driven from a vector table, and a
// three-wait-state memory for backpressure and reset-in-flight sequences.
module tb_data_mem_responder;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sel = 1'b0;

    logic        reqValid = 1'b0;
    logic        reqWrite = 1'b0;
    logic [31:0] reqAddr = 32'h0;
    logic [2:0]  reqFunct3 = 3'b000;
    logic [31:0] reqWdata = 32'h0;
    logic        rspReady = 1'b0;

    logic        reqReady;
    logic        rspValid;
    logic [31:0] rspRdata;
    logic        rspError;

    int errors = 0;
    int checks = 0;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();

    assign bus0.req_valid  = reqValid & ~sel;
    assign bus1.req_valid  = reqValid & sel;
    assign bus0.rsp_ready  = rspReady & ~sel;
    assign bus1.rsp_ready  = rspReady & sel;
    assign bus0.req_write  = reqWrite;
    assign bus1.req_write  = reqWrite;
    assign bus0.req_addr   = reqAddr;
    assign bus1.req_addr   = reqAddr;
    assign bus0.req_funct3 = reqFunct3;
    assign bus1.req_funct3 = reqFunct3;
    assign bus0.req_wdata  = reqWdata;
    assign bus1.req_wdata  = reqWdata;

    assign reqReady = sel ? bus1.req_ready : bus0.req_ready;
    assign rspValid = sel ? bus1.rsp_valid : bus0.rsp_valid;
    assign rspRdata = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
    assign rspError = sel ? bus1.rsp_error : bus0.rsp_error;

    data_mem_responder #(.DEPTH(128), .LATENCY(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );
    data_mem_responder #(.DEPTH(128), .LATENCY(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    vec_t vecs [28];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one request, wait for the response; lat counts cycles after the accept cycle
    task automatic applyStimulus(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, output logic [31:0] rd,
                                 output logic er, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!reqReady && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: req_ready stayed 0 for %0d cycles", guard);
        end
        reqValid  = 1'b1;
        reqWrite  = w;
        reqFunct3 = f3;
        reqAddr   = a;
        reqWdata  = wd;
        @(posedge clk);
        #1 reqValid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!rspValid && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        if (!rspValid) begin
            checks++;
            errors++;
            $display("[TB] FAIL rsp_timeout: rsp_valid stayed 0 for %0d cycles", lat);
        end
        rd = rspRdata;
        er = rspError;
    endtask

    // Complete the response handshake and report req_ready in the following cycle
    task automatic finishResponse(output logic readyAfter);
        rspReady = 1'b1;
        @(posedge clk);
        #1 rspReady = 1'b0;
        @(negedge clk);
        readyAfter = reqReady;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        rdy;

        vecs[0]  = '{1'b1, F3_W,   32'd0,   32'hAABBCCDD, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, F3_B,   32'd0,   32'h00000007, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, F3_B,   32'd0,   32'h0,        32'h00000007, 1'b0};
        vecs[3]  = '{1'b0, F3_W,   32'd0,   32'h0,        32'hAABBCC07, 1'b0};
        vecs[4]  = '{1'b1, F3_W,   32'd4,   32'h80FF7F01, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, F3_B,   32'd7,   32'h0,        32'hFFFFFF80, 1'b0};
        vecs[6]  = '{1'b0, F3_BU,  32'd7,   32'h0,        32'h00000080, 1'b0};
        vecs[7]  = '{1'b0, F3_H,   32'd4,   32'h0,        32'h00007F01, 1'b0};
        vecs[8]  = '{1'b0, F3_HU,  32'd6,   32'h0,        32'h000080FF, 1'b0};
        vecs[9]  = '{1'b0, F3_W,   32'd4,   32'h0,        32'h80FF7F01, 1'b0};
        vecs[10] = '{1'b0, F3_H,   32'd6,   32'h0,        32'hFFFF80FF, 1'b0};
        vecs[11] = '{1'b1, F3_H,   32'd2,   32'h5555BEEF, 32'h0,        1'b0};
        vecs[12] = '{1'b0, F3_W,   32'd0,   32'h0,        32'hBEEFCC07, 1'b0};
        vecs[13] = '{1'b0, F3_W,   32'd2,   32'h0,        32'h0,        1'b1};
        vecs[14] = '{1'b1, F3_B,   32'd127, 32'h0000005A, 32'h0,        1'b0};
        vecs[15] = '{1'b1, F3_H,   32'd127, 32'h00001234, 32'h0,        1'b1};
        vecs[16] = '{1'b0, F3_BU,  32'd127, 32'h0,        32'h0000005A, 1'b0};
        vecs[17] = '{1'b0, F3_B,   32'd128, 32'h0,        32'h0,        1'b1};
        vecs[18] = '{1'b0, 3'b011, 32'd0,   32'h0,        32'h0,        1'b1};
        vecs[19] = '{1'b1, 3'b100, 32'd0,   32'h11111111, 32'h0,        1'b1};
        vecs[20] = '{1'b0, F3_W,   32'd0,   32'h0,        32'hBEEFCC07, 1'b0};
        vecs[21] = '{1'b1, F3_W,   32'd124, 32'h01020304, 32'h0,        1'b0};
        vecs[22] = '{1'b0, F3_H,   32'd126, 32'h0,        32'h00000102, 1'b0};
        vecs[23] = '{1'b0, F3_W,   32'd124, 32'h0,        32'h01020304, 1'b0};
        vecs[24] = '{1'b1, F3_W,   32'd128, 32'h22222222, 32'h0,        1'b1};
        vecs[25] = '{1'b0, F3_W,   32'hFFFFFFFC, 32'h0,   32'h0,        1'b1};
        vecs[26] = '{1'b0, F3_H,   32'd5,   32'h0,        32'h0,        1'b1};
        vecs[27] = '{1'b0, 3'b110, 32'd4,   32'h0,        32'h0,        1'b1};

        // Reset values on both instances
        repeat (3) @(negedge clk);
        sel = 1'b0;
        #1;
        checkOutput("rst0_req_ready", 32'(reqReady), 32'd1);
        checkOutput("rst0_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("rst0_rsp_rdata", rspRdata, 32'd0);
        checkOutput("rst0_rsp_error", 32'(rspError), 32'd0);
        sel = 1'b1;
        #1;
        checkOutput("rst1_req_ready", 32'(reqReady), 32'd1);
        checkOutput("rst1_rsp_valid", 32'(rspValid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Zero-wait-state vectors
        sel = 1'b0;
        for (int i = 0; i < 28; i++) begin
            applyStimulus(vecs[i].write, vecs[i].funct3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            checkOutput($sformatf("v%0d_rdata", i), rd, vecs[i].expRdata);
            checkOutput($sformatf("v%0d_error", i), 32'(er), 32'(vecs[i].expErr));
            checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'd0);
            finishResponse(rdy);
            checkOutput($sformatf("v%0d_ready_after", i), 32'(rdy), 32'd1);
        end
        checkOutput("mem0_byte", 32'(dut0.mem[0]), 32'h07);
        checkOutput("mem127_byte", 32'(dut0.mem[127]), 32'h01);

        // Three wait states: prime two words
        sel = 1'b1;
        applyStimulus(1'b1, F3_W, 32'd8, 32'h11223344, rd, er, lat);
        checkOutput("l3_sw8_latency", 32'(lat), 32'd3);
        finishResponse(rdy);
        applyStimulus(1'b1, F3_W, 32'd4, 32'h80FF7F01, rd, er, lat);
        checkOutput("l3_sw4_error", 32'(er), 32'd0);
        finishResponse(rdy);

        // Backpressure: response must hold while rsp_ready is low
        applyStimulus(1'b0, F3_W, 32'd4, 32'h0, rd, er, lat);
        checkOutput("bp_latency", 32'(lat), 32'd3);
        checkOutput("bp_rdata", rd, 32'h80FF7F01);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_hold%0d_valid", k), 32'(rspValid), 32'd1);
            checkOutput($sformatf("bp_hold%0d_rdata", k), rspRdata, 32'h80FF7F01);
            checkOutput($sformatf("bp_hold%0d_req_ready", k), 32'(reqReady), 32'd0);
        end
        finishResponse(rdy);
        checkOutput("bp_ready_after", 32'(rdy), 32'd1);

        // Reset while a store is waiting
        @(negedge clk);
        reqValid  = 1'b1;
        reqWrite  = 1'b1;
        reqFunct3 = F3_W;
        reqAddr   = 32'd8;
        reqWdata  = 32'hDEADBEEF;
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(negedge clk);
        checkOutput("rw_in_wait_req_ready", 32'(reqReady), 32'd0);
        checkOutput("rw_in_wait_rsp_valid", 32'(rspValid), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rw_rst_req_ready", 32'(reqReady), 32'd1);
        checkOutput("rw_rst_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("rw_rst_rsp_rdata", rspRdata, 32'd0);
        checkOutput("rw_rst_rsp_error", 32'(rspError), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("rw_after_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("rw_after_req_ready", 32'(reqReady), 32'd1);
        checkOutput("rw_mem8", 32'(dut1.mem[8]), 32'h44);
        checkOutput("rw_mem11", 32'(dut1.mem[11]), 32'h11);
        applyStimulus(1'b0, F3_W, 32'd8, 32'h0, rd, er, lat);
        checkOutput("rw_reload_rdata", rd, 32'h11223344);
        checkOutput("rw_reload_latency", 32'(lat), 32'd3);
        finishResponse(rdy);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
